mp_regfile_mp: RTL and testbench
================================

Name: mp_regfile_mp

Overview:
- Parametrised multi-port successor of the core register file, for the dual-issue core.
- Holds 2**AW half-registers of HW bits, paired into 2**(AW-1) words of 2*HW bits.
- Provides NRD asynchronous read ports, each with half and word outputs, and two write ports with half or word granularity.
- Adds same-cycle write-through bypass, reset-cleared contents, and a per-half pending-write scoreboard that drives per-port busy flags to the issue stage.

Parameters:
- AW, 5, half-register index width; word index is idx[AW-1:1].
- HW, 16, half-register width in bits.
- NRD, 4, number of read ports.

Ports:
- sys_clk  in  1  core clock; all state updates on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- rd_idx  in  NRD*AW  per-port half index; port k occupies [k*AW +: AW].
- rd_wide  in  NRD  per-port access size for busy evaluation: 1 = word, 0 = half.
- rd_d16  out  NRD*HW  per-port half data.
- rd_d32  out  NRD*2*HW  per-port word data.
- rd_busy  out  NRD  per-port pending-write flag.
- wr0_en, wr1_en  in  1  write enables.
- wr0_wide, wr1_wide  in  1  1 = word write, 0 = half write.
- wr0_idx, wr1_idx  in  AW  destination half index.
- wr0_data, wr1_data  in  2*HW  write data; a half write uses [HW-1:0].
- rsv_en  in  1  reserve destination (long-latency op issued).
- rsv_wide  in  1  reservation size.
- rsv_idx  in  AW  reserved half index.
- pend  out  2**AW  raw scoreboard bits, for debug and perf.

Behaviour:
- Reset (sys_rst_n low, asynchronous): all array words 0, all pend bits 0.
  - Read outputs are therefore 0 and rd_busy is 0 during and after reset.
- Word 0 (half indices 0 and 1) is hardwired zero.
  - Writes and reservations targeting word 0 are discarded.
  - Reads of word 0 return 0 on both rd_d16 and rd_d32.
  - rd_busy is 0 for any access to word 0.
- Write masking:
  - Word write updates both halves of word idx[AW-1:1]; idx[0] is ignored.
  - Half write updates only half idx[0]: 0 = low, 1 = high.
- Write collision (both ports hit the same half in one cycle): wr1 wins for that half.
  - Non-overlapping halves of the same word both commit.
- Read data is combinational, zero latency:
  - rd_d32 = {high half, low half} of word idx[AW-1:1].
  - rd_d16 = high half if idx[0] = 1, else low half.
- Write-through bypass: a read of a half being written this cycle returns the incoming data, not the stored value.
  - Per-half priority: wr1 over wr0 over array.
  - A word read with only one half being written merges the bypassed half with the stored other half.
- Scoreboard, per half, updated on the clock edge:
  - rsv_en sets the pend bit(s) of the addressed half or both halves.
  - Any committing write clears the pend bit(s) of the halves it writes.
  - Reservation and clear of the same half in one cycle: set wins (newer producer).
  - A reserved half that is already pending stays pending; there is no counting.
- rd_busy[k] = OR of the pend bits for the halves port k reads (word: both, half: one), excluding halves written this cycle.
  - Same-cycle producer-to-consumer therefore never stalls.
- Reservation takes effect the cycle after rsv_en; it does not affect rd_busy in the same cycle.
- Reset asserted mid-operation clears all pend bits immediately; any in-flight producer's later write then commits normally.
- Widths: all index compares are AW bits; no arithmetic beyond muxing. Implementation target is 150-250 lines.

Test Plan:
- Reset, then read all 32 indices on 4 ports -> rd_d32 = 0, rd_d16 = 0, rd_busy = 0, pend = 0.
- wr0 word idx 6 data 0xDEADBEEF; next cycle read idx 6 and 7 -> rd_d32 = 0xDEADBEEF; rd_d16 = 0xBEEF (idx 6) and 0xDEAD (idx 7).
- Bypass merge: with stored word at idx 6 = 0xDEADBEEF, same cycle wr1 half idx 7 data 0x1234 and read idx 6 wide -> rd_d32 = 0x1234BEEF.
- Collision: wr0 word idx 10 = 0xAAAA5555 and wr1 half idx 10 = 0x0F0F in the same cycle -> word 5 reads 0xAAAA0F0F.
- Scoreboard:
  - rsv_en wide idx 12, then read idx 13 half -> rd_busy = 1.
  - Cycle of wr0 half idx 12 -> idx 12 read not busy, idx 13 read still busy.
  - wr1 half idx 13 -> pend[13:12] = 0.
- Set-wins and word 0:
  - rsv idx 20 in the same cycle as a write to idx 20 -> pend[20] = 1.
  - wr0 word idx 0 = 0xFFFFFFFF -> reads 0.
  - rsv idx 1 -> pend unchanged.

Source files
------------

// File: rtl/mp_regfile_mp.sv
// Multi-port half/word register file with write-through bypass and pending-write scoreboard.
// Latency: reads combinational (0 cycles); writes and reservations visible after the next rising edge.
// Backpressure: none inside; rd_busy flags pending producers so the issue stage can stall.
module mp_regfile_mp #(
    parameter int AW  = 5,
    parameter int HW  = 16,
    parameter int NRD = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [NRD*AW-1:0]     rd_idx,
    input  logic [NRD-1:0]        rd_wide,
    output logic [NRD*HW-1:0]     rd_d16,
    output logic [NRD*2*HW-1:0]   rd_d32,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wr0_en,
    input  logic                  wr1_en,
    input  logic                  wr0_wide,
    input  logic                  wr1_wide,
    input  logic [AW-1:0]         wr0_idx,
    input  logic [AW-1:0]         wr1_idx,
    input  logic [2*HW-1:0]       wr0_data,
    input  logic [2*HW-1:0]       wr1_data,
    input  logic                  rsv_en,
    input  logic                  rsv_wide,
    input  logic [AW-1:0]         rsv_idx,
    output logic [2**AW-1:0]      pend
);

    localparam int NH = 2**AW;

    logic [HW-1:0] mem_q [NH];
    logic [HW-1:0] wr_val [NH];
    logic [HW-1:0] eff [NH];
    logic [NH-1:0] pend_q;
    logic [NH-1:0] w0_hit;
    logic [NH-1:0] w1_hit;
    logic [NH-1:0] wr_hit;
    logic [NH-1:0] rsv_hit;
    logic [NH-1:0] live_pend;

    // Does an access (word or half) at idx cover half h? Word 0 is never a target.
    function automatic logic covers(input logic en, input logic wide,
                                    input logic [AW-1:0] idx, input logic [AW-1:0] h);
        return en && (idx[AW-1:1] == h[AW-1:1]) && (wide || (idx[0] == h[0]))
               && (h[AW-1:1] != '0);
    endfunction

    function automatic logic [HW-1:0] half_sel(input logic wide, input logic [2*HW-1:0] d,
                                               input logic odd);
        return (wide && odd) ? d[2*HW-1:HW] : d[HW-1:0];
    endfunction

    always_comb begin
        w0_hit  = '0;
        w1_hit  = '0;
        rsv_hit = '0;
        for (int h = 0; h < NH; h++) begin
            w0_hit[h]  = covers(wr0_en, wr0_wide, wr0_idx, AW'(h));
            w1_hit[h]  = covers(wr1_en, wr1_wide, wr1_idx, AW'(h));
            rsv_hit[h] = covers(rsv_en, rsv_wide, rsv_idx, AW'(h));
        end
    end

    // Per-half merge: wr1 over wr0 over the stored value.
    always_comb begin
        for (int h = 0; h < NH; h++) begin
            wr_val[h] = w1_hit[h] ? half_sel(wr1_wide, wr1_data, (h % 2) == 1)
                                  : half_sel(wr0_wide, wr0_data, (h % 2) == 1);
            eff[h]    = wr_hit[h] ? wr_val[h] : mem_q[h];
        end
    end

    assign wr_hit    = w0_hit | w1_hit;
    assign live_pend = pend_q & ~wr_hit;
    assign pend      = pend_q;

    // A reservation landing on a half being cleared wins: it is the newer producer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int h = 0; h < NH; h++) begin
                mem_q[h] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int h = 0; h < NH; h++) begin
                if (wr_hit[h]) begin
                    mem_q[h] <= wr_val[h];
                end
            end
            pend_q <= rsv_hit | (pend_q & ~wr_hit);
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ri;
        logic [AW-1:0] rlo;
        logic [AW-1:0] rhi;

        assign ri  = rd_idx[k*AW +: AW];
        assign rlo = {ri[AW-1:1], 1'b0};
        assign rhi = {ri[AW-1:1], 1'b1};

        assign rd_d16[k*HW +: HW]       = eff[ri];
        assign rd_d32[k*2*HW +: 2*HW]   = {eff[rhi], eff[rlo]};
        assign rd_busy[k] = rd_wide[k] ? (live_pend[rlo] | live_pend[rhi]) : live_pend[ri];
    end

endmodule

// File: tb/tb_mp_regfile_mp.sv
// Bench for mp_regfile_mp: directed scenarios plus randomized traffic against a half-array model.
module tb_mp_regfile_mp;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [19:0]   rd_idx;
    logic [3:0]    rd_wide;
    logic [63:0]   rd_d16;
    logic [127:0]  rd_d32;
    logic [3:0]    rd_busy;
    logic          wr0_en, wr1_en, wr0_wide, wr1_wide;
    logic [4:0]    wr0_idx, wr1_idx;
    logic [31:0]   wr0_data, wr1_data;
    logic          rsv_en, rsv_wide;
    logic [4:0]    rsv_idx;
    logic [31:0]   pend;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference state: stored halves, pending bits, and this cycle's effective writes.
    logic [15:0] m [32];
    logic [31:0] p;
    logic [31:0] bh;
    logic [15:0] bv [32];

    mp_regfile_mp #(.AW(5), .HW(16), .NRD(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .rd_idx(rd_idx), .rd_wide(rd_wide), .rd_d16(rd_d16), .rd_d32(rd_d32), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr1_en(wr1_en), .wr0_wide(wr0_wide), .wr1_wide(wr1_wide),
        .wr0_idx(wr0_idx), .wr1_idx(wr1_idx), .wr0_data(wr0_data), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_wide(rsv_wide), .rsv_idx(rsv_idx), .pend(pend)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    task automatic idle;
        wr0_en = 0; wr1_en = 0; wr0_wide = 0; wr1_wide = 0;
        wr0_idx = 0; wr1_idx = 0; wr0_data = 0; wr1_data = 0;
        rsv_en = 0; rsv_wide = 0; rsv_idx = 0;
    endtask

    task automatic set_port(input int k, input logic [4:0] idx, input logic wide);
        rd_idx[k*5 +: 5] = idx;
        rd_wide[k] = wide;
    endtask

    task automatic model_reset;
        for (int h = 0; h < 32; h++) m[h] = 16'h0;
        p = 32'h0;
    endtask

    // Apply one write port's effect in program order; later calls overwrite earlier ones.
    task automatic apply_wr(input logic en, input logic wide, input logic [4:0] idx,
                            input logic [31:0] d);
        logic [3:0] w;
        w = idx[4:1];
        if (en && w != 4'd0) begin
            if (wide) begin
                bh[{w, 1'b0}] = 1'b1; bv[{w, 1'b0}] = d[15:0];
                bh[{w, 1'b1}] = 1'b1; bv[{w, 1'b1}] = d[31:16];
            end else begin
                bh[idx] = 1'b1; bv[idx] = d[15:0];
            end
        end
    endtask

    task automatic calc_writes;
        bh = 32'h0;
        for (int h = 0; h < 32; h++) bv[h] = 16'h0;
        apply_wr(wr0_en, wr0_wide, wr0_idx, wr0_data);
        apply_wr(wr1_en, wr1_wide, wr1_idx, wr1_data);
    endtask

    function automatic logic [15:0] eh(input logic [4:0] h);
        return bh[h] ? bv[h] : m[h];
    endfunction

    function automatic logic [31:0] ew(input logic [4:0] idx);
        logic [3:0] w;
        w = idx[4:1];
        return {eh({w, 1'b1}), eh({w, 1'b0})};
    endfunction

    function automatic logic eb(input logic [4:0] idx, input logic wide);
        logic [3:0] w;
        logic lo, hi;
        w = idx[4:1];
        lo = p[{w, 1'b0}] && !bh[{w, 1'b0}];
        hi = p[{w, 1'b1}] && !bh[{w, 1'b1}];
        if (wide) return lo | hi;
        return p[idx] && !bh[idx];
    endfunction

    // Advance one clock edge and update the model from the inputs sampled there.
    task automatic tick;
        logic [3:0] w;
        @(posedge sys_clk);
        calc_writes();
        for (int h = 0; h < 32; h++) if (bh[h]) m[h] = bv[h];
        p = p & ~bh;
        w = rsv_idx[4:1];
        if (rsv_en && w != 4'd0) begin
            if (rsv_wide) begin
                p[{w, 1'b0}] = 1'b1;
                p[{w, 1'b1}] = 1'b1;
            end else begin
                p[rsv_idx] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        sys_rst_n = 0;
        idle();
        rd_idx = 0; rd_wide = 0;
        model_reset();
        #12;
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 4; k++) set_port(k, 5'(g*4 + k), 1'((g + k) % 2));
            #1;
            n_cmp++;
            if ({rd_d32, rd_d16, rd_busy, pend} !== '0) begin
                n_fail++;
                $display("FAIL reset_in g=%0d: d32=%h d16=%h busy=%b pend=%h, want all 0",
                         g, rd_d32, rd_d16, rd_busy, pend);
            end
        end
        @(negedge sys_clk);
        sys_rst_n = 1;
        @(posedge sys_clk); #1;
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 4; k++) set_port(k, 5'(g*4 + k), 1'((g + k + 1) % 2));
            @(negedge sys_clk);
            n_cmp++;
            if ({rd_d32, rd_d16, rd_busy, pend} !== '0) begin
                n_fail++;
                $display("FAIL reset_after g=%0d: d32=%h d16=%h busy=%b pend=%h, want all 0",
                         g, rd_d32, rd_d16, rd_busy, pend);
            end
            tick();
        end
    endtask

    task automatic test_word_write;
        idle();
        wr0_en = 1; wr0_wide = 1; wr0_idx = 6; wr0_data = 32'hDEADBEEF;
        tick();
        idle();
        set_port(0, 6, 1); set_port(1, 7, 0); set_port(2, 7, 1); set_port(3, 6, 0);
        @(negedge sys_clk);
        n_cmp++;
        if (rd_d32[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL word_d32_idx6: got %h want deadbeef", rd_d32[31:0]);
        end
        n_cmp++;
        if (rd_d32[95:64] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL word_d32_idx7: got %h want deadbeef", rd_d32[95:64]);
        end
        n_cmp++;
        if (rd_d16[63:48] !== 16'hBEEF) begin
            n_fail++; $display("FAIL word_d16_idx6: got %h want beef", rd_d16[63:48]);
        end
        n_cmp++;
        if (rd_d16[31:16] !== 16'hDEAD) begin
            n_fail++; $display("FAIL word_d16_idx7: got %h want dead", rd_d16[31:16]);
        end
        tick();
    endtask

    task automatic test_bypass_merge;
        idle();
        wr1_en = 1; wr1_wide = 0; wr1_idx = 7; wr1_data = 32'h00001234;
        set_port(0, 6, 1); set_port(1, 7, 0);
        @(negedge sys_clk);
        n_cmp++;
        if (rd_d32[31:0] !== 32'h1234BEEF) begin
            n_fail++; $display("FAIL bypass_merge_d32: got %h want 1234beef", rd_d32[31:0]);
        end
        n_cmp++;
        if (rd_d16[31:16] !== 16'h1234) begin
            n_fail++; $display("FAIL bypass_d16: got %h want 1234", rd_d16[31:16]);
        end
        tick();
        idle();
        @(negedge sys_clk);
        n_cmp++;
        if (rd_d32[31:0] !== 32'h1234BEEF) begin
            n_fail++; $display("FAIL bypass_stored: got %h want 1234beef", rd_d32[31:0]);
        end
        tick();
    endtask

    task automatic test_collision;
        idle();
        wr0_en = 1; wr0_wide = 1; wr0_idx = 10; wr0_data = 32'hAAAA5555;
        wr1_en = 1; wr1_wide = 0; wr1_idx = 10; wr1_data = 32'h00000F0F;
        set_port(0, 10, 1); set_port(1, 11, 0);
        @(negedge sys_clk);
        n_cmp++;
        if (rd_d32[31:0] !== 32'hAAAA0F0F) begin
            n_fail++; $display("FAIL collide_bypass: got %h want aaaa0f0f", rd_d32[31:0]);
        end
        tick();
        idle();
        @(negedge sys_clk);
        n_cmp++;
        if (rd_d32[31:0] !== 32'hAAAA0F0F) begin
            n_fail++; $display("FAIL collide_stored: got %h want aaaa0f0f", rd_d32[31:0]);
        end
        n_cmp++;
        if (rd_d16[31:16] !== 16'hAAAA) begin
            n_fail++; $display("FAIL collide_high: got %h want aaaa", rd_d16[31:16]);
        end
        tick();
    endtask

    task automatic test_scoreboard;
        idle();
        rsv_en = 1; rsv_wide = 1; rsv_idx = 12;
        set_port(0, 13, 0); set_port(1, 12, 0); set_port(2, 12, 1);
        @(negedge sys_clk);
        n_cmp++;
        if (rd_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL rsv_same_cycle_busy: got %b want 0", rd_busy[0]);
        end
        tick();
        idle();
        @(negedge sys_clk);
        n_cmp++;
        if (rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL rsv_busy13: got %b want 1", rd_busy[0]);
        end
        n_cmp++;
        if (pend[13:12] !== 2'b11) begin
            n_fail++; $display("FAIL rsv_pend: got %b want 11", pend[13:12]);
        end
        tick();
        wr0_en = 1; wr0_wide = 0; wr0_idx = 12; wr0_data = 32'h00004321;
        @(negedge sys_clk);
        n_cmp++;
        if (rd_busy[1] !== 1'b0) begin
            n_fail++; $display("FAIL sb_idx12_written: got %b want 0", rd_busy[1]);
        end
        n_cmp++;
        if (rd_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL sb_idx13_still: got %b want 1", rd_busy[0]);
        end
        n_cmp++;
        if (rd_busy[2] !== 1'b1) begin
            n_fail++; $display("FAIL sb_word_partial: got %b want 1", rd_busy[2]);
        end
        tick();
        idle();
        @(negedge sys_clk);
        n_cmp++;
        if (pend[13:12] !== 2'b10) begin
            n_fail++; $display("FAIL sb_pend_after_lo: got %b want 10", pend[13:12]);
        end
        tick();
        wr1_en = 1; wr1_wide = 0; wr1_idx = 13; wr1_data = 32'h00008765;
        tick();
        idle();
        @(negedge sys_clk);
        n_cmp++;
        if (pend[13:12] !== 2'b00) begin
            n_fail++; $display("FAIL sb_pend_cleared: got %b want 00", pend[13:12]);
        end
        n_cmp++;
        if (rd_busy[2:0] !== 3'b000) begin
            n_fail++; $display("FAIL sb_busy_cleared: got %b want 000", rd_busy[2:0]);
        end
        tick();
    endtask

    task automatic test_set_wins_word0;
        idle();
        rsv_en = 1; rsv_wide = 0; rsv_idx = 20;
        wr0_en = 1; wr0_wide = 0; wr0_idx = 20; wr0_data = 32'h00007777;
        tick();
        idle();
        set_port(0, 20, 0);
        @(negedge sys_clk);
        n_cmp++;
        if (pend[20] !== 1'b1) begin
            n_fail++; $display("FAIL set_wins_pend20: got %b want 1", pend[20]);
        end
        n_cmp++;
        if (rd_busy[0] !== 1'b1 || rd_d16[15:0] !== 16'h7777) begin
            n_fail++; $display("FAIL set_wins_read: busy=%b d16=%h want 1/7777",
                               rd_busy[0], rd_d16[15:0]);
        end
        tick();
        wr0_en = 1; wr0_wide = 1; wr0_idx = 0; wr0_data = 32'hFFFFFFFF;
        set_port(0, 0, 1); set_port(1, 1, 0); set_port(2, 1, 1);
        @(negedge sys_clk);
        n_cmp++;
        if (rd_d32[31:0] !== 32'h0 || rd_d16[31:16] !== 16'h0 || rd_busy[2:0] !== 3'b000) begin
            n_fail++; $display("FAIL word0_bypass: d32=%h d16=%h busy=%b want 0",
                               rd_d32[31:0], rd_d16[31:16], rd_busy[2:0]);
        end
        tick();
        idle();
        rsv_en = 1; rsv_wide = 0; rsv_idx = 1;
        @(negedge sys_clk);
        n_cmp++;
        if (rd_d32[95:64] !== 32'h0 || rd_d16[31:16] !== 16'h0) begin
            n_fail++; $display("FAIL word0_stored: d32=%h d16=%h want 0",
                               rd_d32[95:64], rd_d16[31:16]);
        end
        tick();
        idle();
        @(negedge sys_clk);
        n_cmp++;
        if (pend !== p || pend[1:0] !== 2'b00) begin
            n_fail++; $display("FAIL word0_rsv: pend=%h want %h", pend, p);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        idle();
        rsv_en = 1; rsv_wide = 1; rsv_idx = 24;
        tick();
        idle();
        set_port(0, 6, 1);
        @(negedge sys_clk);
        n_cmp++;
        if (pend[25:24] !== 2'b11) begin
            n_fail++; $display("FAIL mid_pre_pend: got %b want 11", pend[25:24]);
        end
        sys_rst_n = 0;
        #1;
        n_cmp++;
        if (pend !== 32'h0 || rd_d32[31:0] !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_async: pend=%h d32=%h want 0", pend, rd_d32[31:0]);
        end
        model_reset();
        @(posedge sys_clk); #1;
        sys_rst_n = 1;
        wr0_en = 1; wr0_wide = 0; wr0_idx = 24; wr0_data = 32'h00005A5A;
        tick();
        idle();
        set_port(0, 24, 1); set_port(1, 24, 0);
        @(negedge sys_clk);
        n_cmp++;
        if (rd_d16[31:16] !== 16'h5A5A || rd_d32[31:0] !== 32'h00005A5A || rd_busy[1:0] !== 2'b00) begin
            n_fail++; $display("FAIL mid_late_write: d16=%h d32=%h busy=%b want 5a5a/00005a5a/00",
                               rd_d16[31:16], rd_d32[31:0], rd_busy[1:0]);
        end
        tick();
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            wr0_en = 1'($urandom_range(0, 1)); wr0_wide = 1'($urandom_range(0, 1));
            wr1_en = 1'($urandom_range(0, 1)); wr1_wide = 1'($urandom_range(0, 1));
            wr0_idx = 5'($urandom_range(0, 31)); wr1_idx = 5'($urandom_range(0, 31));
            wr0_data = $urandom; wr1_data = $urandom;
            rsv_en = ($urandom_range(0, 2) == 0); rsv_wide = 1'($urandom_range(0, 1));
            rsv_idx = 5'($urandom_range(0, 31));
            if (c % 10 == 0) wr1_idx = wr0_idx;
            for (int k = 0; k < 4; k++) begin
                set_port(k, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                if (c % 4 == 0) set_port(k, (k % 2 == 0) ? wr0_idx : wr1_idx, 1'($urandom_range(0, 1)));
            end
            @(negedge sys_clk);
            calc_writes();
            for (int k = 0; k < 4; k++) begin
                logic [4:0] ix;
                ix = rd_idx[k*5 +: 5];
                n_cmp++;
                if (rd_d16[k*16 +: 16] !== eh(ix) || rd_d32[k*32 +: 32] !== ew(ix)
                    || rd_busy[k] !== eb(ix, rd_wide[k])) begin
                    n_fail++;
                    $display("FAIL rand_c%0d_p%0d idx=%0d: d16=%h d32=%h busy=%b want %h %h %b",
                             c, k, ix, rd_d16[k*16 +: 16], rd_d32[k*32 +: 32], rd_busy[k],
                             eh(ix), ew(ix), eb(ix, rd_wide[k]));
                end
            end
            n_cmp++;
            if (pend !== p) begin
                n_fail++; $display("FAIL rand_pend_c%0d: got %h want %h", c, pend, p);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_bypass_merge();
        test_collision();
        test_scoreboard();
        test_set_wins_word0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
